// File: rtl/abs_diff_err_pkg.sv
// Shared types and width helpers for the absolute-difference error monitor.
package abs_diff_err_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SWEEP,
    S_DRAIN,
    S_DONE
  } state_e;

  localparam int OPW_DEF = 2;
  localparam int IN_W    = 2 * OPW_DEF;
  localparam int SUM_W   = 3 * OPW_DEF;
  localparam int CNT_W   = 2 * OPW_DEF + 1;

  function automatic int in_w(input int opw);
    return 2 * opw;
  endfunction

  function automatic int sum_w(input int opw);
    return 3 * opw;
  endfunction

  function automatic int cnt_w(input int opw);
    return 2 * opw + 1;
  endfunction

endpackage

// File: rtl/abs_diff_exact.sv
// Exact combinational |a-b| golden model on OPW-bit unsigned operands.
module abs_diff_exact #(
  parameter int OPW = 2
) (
  input  logic [OPW-1:0] i_a,
  input  logic [OPW-1:0] i_b,
  output logic [OPW-1:0] o_abs
);

  logic signed [OPW:0] w_diff;
  logic signed [OPW:0] w_neg;

  assign w_diff = $signed({1'b0, i_a}) - $signed({1'b0, i_b});
  assign w_neg  = -w_diff;
  assign o_abs  = w_diff[OPW] ? w_neg[OPW-1:0] : w_diff[OPW-1:0];

endmodule

// File: rtl/abs_diff_err_monitor.sv
// Exhaustive sweep of an approximate |a-b| circuit against the exact model,
// accumulating max error, error sum and mismatch count.
module abs_diff_err_monitor
  import abs_diff_err_pkg::*;
#(
  parameter int OPW = 2,
  parameter int ET  = 1,
  parameter int LAT = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic [in_w(OPW)-1:0]    dut_in,
  input  logic [OPW-1:0]          dut_out,
  output logic                    busy,
  output logic                    done,
  output logic [OPW-1:0]          max_err,
  output logic [sum_w(OPW)-1:0]   err_sum,
  output logic [cnt_w(OPW)-1:0]   mismatches,
  output logic                    pass
);

  localparam int W_IN  = in_w(OPW);
  localparam int W_SUM = sum_w(OPW);
  localparam int W_CNT = cnt_w(OPW);
  localparam int CW    = (LAT > 0) ? $clog2(LAT + 1) : 1;
  localparam logic [31:0] ET_V = ET;

  state_e               r_state;
  state_e               w_state_nxt;
  logic [W_IN-1:0]      r_vec;
  logic [CW-1:0]        r_drain_cnt;
  logic [OPW-1:0]       r_max;
  logic [W_SUM-1:0]     r_sum;
  logic [W_CNT-1:0]     r_mis;
  logic                 r_pass;
  logic [OPW-1:0]       w_exact;
  logic [OPW-1:0]       w_cmp_exact;
  logic                 w_cmp_vld;
  logic [OPW-1:0]       w_err;
  logic [OPW-1:0]       w_max_nxt;
  logic                 w_push;
  logic                 w_last_vec;
  logic                 w_accept;

  assign w_push     = (r_state == S_SWEEP);
  assign w_last_vec = &r_vec;
  assign w_accept   = (r_state == S_IDLE) && start;

  abs_diff_exact #(.OPW(OPW)) u_gold (
    .i_a   (r_vec[OPW-1:0]),
    .i_b   (r_vec[W_IN-1:OPW]),
    .o_abs (w_exact)
  );

  // Delay line: exact result and valid tag travel LAT cycles to meet dut_out
  if (LAT == 0) begin : g_comb
    assign w_cmp_exact = w_exact;
    assign w_cmp_vld   = w_push;
  end else begin : g_dly
    logic [OPW-1:0] r_exact_p [LAT];
    logic           r_vld_p   [LAT];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < LAT; i++) begin
          r_exact_p[i] <= '0;
          r_vld_p[i]   <= 1'b0;
        end
      end else begin
        r_exact_p[0] <= w_exact;
        r_vld_p[0]   <= w_push;
        for (int i = 1; i < LAT; i++) begin
          r_exact_p[i] <= r_exact_p[i-1];
          r_vld_p[i]   <= r_vld_p[i-1];
        end
      end
    end

    assign w_cmp_exact = r_exact_p[LAT-1];
    assign w_cmp_vld   = r_vld_p[LAT-1];
  end

  abs_diff_exact #(.OPW(OPW)) u_err (
    .i_a   (w_cmp_exact),
    .i_b   (dut_out),
    .o_abs (w_err)
  );

  assign w_max_nxt = (w_cmp_vld && (w_err > r_max)) ? w_err : r_max;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_SWEEP;
      S_SWEEP: begin
        if (w_last_vec) begin
          if (LAT == 0) w_state_nxt = S_DONE;
          else          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: if (r_drain_cnt == CW'(LAT - 1)) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state != S_IDLE);
    done = (r_state == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vec       <= '0;
      r_drain_cnt <= '0;
    end else begin
      if (w_accept)                   r_vec <= '0;
      else if (w_push && !w_last_vec) r_vec <= r_vec + W_IN'(1);
      if (r_state == S_DRAIN) r_drain_cnt <= r_drain_cnt + CW'(1);
      else                    r_drain_cnt <= '0;
    end
  end

  // Pass is decided on the edge entering DONE, including that edge's compare
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_max  <= '0;
      r_sum  <= '0;
      r_mis  <= '0;
      r_pass <= 1'b0;
    end else if (w_accept) begin
      r_max  <= '0;
      r_sum  <= '0;
      r_mis  <= '0;
      r_pass <= 1'b0;
    end else begin
      if (w_cmp_vld) begin
        r_max <= w_max_nxt;
        r_sum <= r_sum + W_SUM'(w_err);
        r_mis <= r_mis + W_CNT'(w_err != '0);
      end
      if (w_state_nxt == S_DONE && r_state != S_DONE)
        r_pass <= (32'(w_max_nxt) <= ET_V);
    end
  end

  assign dut_in     = r_vec;
  assign max_err    = r_max;
  assign err_sum    = r_sum;
  assign mismatches = r_mis;
  assign pass       = r_pass;

endmodule

// File: tb/tb_abs_diff_err_monitor.sv
// Directed bench: exact, tied-zero, bit0-forced and pipelined DUT models.
module tb_abs_diff_err_monitor;

  logic       clk;
  logic       rst;
  logic       start0, start1;
  logic [3:0] dut_in0, dut_in1;
  logic [1:0] dut_out0, dut_out1;
  logic       busy0, busy1, done0, done1, pass0, pass1;
  logic [1:0] max0, max1;
  logic [5:0] sum0, sum1;
  logic [4:0] mis0, mis1;
  logic [1:0] r_p1, r_p2;
  int         mode;
  int         sel;
  int         n_checks;
  int         n_fail;
  int         cyc;

  abs_diff_err_monitor #(.OPW(2), .ET(1), .LAT(0)) u_mon0 (
    .clk(clk), .rst(rst), .start(start0), .dut_in(dut_in0), .dut_out(dut_out0),
    .busy(busy0), .done(done0), .max_err(max0), .err_sum(sum0),
    .mismatches(mis0), .pass(pass0)
  );

  abs_diff_err_monitor #(.OPW(2), .ET(1), .LAT(2)) u_mon1 (
    .clk(clk), .rst(rst), .start(start1), .dut_in(dut_in1), .dut_out(dut_out1),
    .busy(busy1), .done(done1), .max_err(max1), .err_sum(sum1),
    .mismatches(mis1), .pass(pass1)
  );

  function automatic logic [1:0] ad(input logic [3:0] v);
    logic [1:0] a, b;
    a = v[1:0];
    b = v[3:2];
    return (a > b) ? (a - b) : (b - a);
  endfunction

  always_comb begin
    case (mode)
      1:       dut_out0 = 2'd0;
      2:       dut_out0 = ad(dut_in0) | 2'd1;
      default: dut_out0 = ad(dut_in0);
    endcase
  end

  always @(posedge clk) begin
    r_p1 <= ad(dut_in1);
    r_p2 <= r_p1;
  end
  assign dut_out1 = r_p2;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_start(input logic v);
    if (sel == 0) start0 = v;
    else          start1 = v;
  endtask

  function automatic logic sel_done();
    return (sel == 0) ? done0 : done1;
  endfunction

  // Returns the number of rising edges from the start edge to the done cycle
  task automatic run(input int inst, input int pulse_at, output int n);
    sel = inst;
    @(negedge clk); set_start(1'b1);
    @(posedge clk);
    @(negedge clk); set_start(1'b0);
    n = 1;
    while (!sel_done() && n < 100) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      set_start(n == pulse_at);
    end
    set_start(1'b0);
  endtask

  task automatic chk_stats0(input string tag, input int mx, input int sm, input int ms, input int ps);
    chk({tag, "_max"},  32'(max0), 32'(mx));
    chk({tag, "_sum"},  32'(sum0), 32'(sm));
    chk({tag, "_mis"},  32'(mis0), 32'(ms));
    chk({tag, "_pass"}, 32'(pass0), 32'(ps));
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    mode     = 0;
    sel      = 0;
    rst      = 1'b1;
    start0   = 1'b0;
    start1   = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_dut_in", 32'(dut_in0), 0);
    chk("rst_busy",   32'(busy0), 0);
    chk("rst_done",   32'(done0), 0);
    chk_stats0("rst", 0, 0, 0, 0);
    rst = 1'b0;

    mode = 0;
    run(0, 0, cyc);
    chk("exact_lat", 32'(cyc), 17);
    chk("exact_done", 32'(done0), 1);
    chk_stats0("exact", 0, 0, 0, 1);
    @(negedge clk);
    chk("exact_busy_after", 32'(busy0), 0);
    chk("exact_done_after", 32'(done0), 0);

    mode = 1;
    run(0, 0, cyc);
    chk("zero_lat", 32'(cyc), 17);
    chk_stats0("zero", 3, 20, 12, 0);
    @(negedge clk);
    chk_stats0("zero_hold", 3, 20, 12, 0);

    mode = 2;
    run(0, 0, cyc);
    chk_stats0("or1", 1, 8, 8, 1);

    run(1, 0, cyc);
    chk("pipe_lat",  32'(cyc), 19);
    chk("pipe_max",  32'(max1), 0);
    chk("pipe_sum",  32'(sum1), 0);
    chk("pipe_mis",  32'(mis1), 0);
    chk("pipe_pass", 32'(pass1), 1);

    mode = 0;
    run(0, 5, cyc);
    chk("pulse_lat", 32'(cyc), 17);
    chk_stats0("pulse", 0, 0, 0, 1);

    mode = 1;
    sel  = 0;
    @(negedge clk); start0 = 1'b1;
    @(posedge clk);
    @(negedge clk); start0 = 1'b0;
    repeat (8) @(negedge clk);
    chk("mid_busy", 32'(busy0), 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy",   32'(busy0), 0);
    chk("mid_rst_dut_in", 32'(dut_in0), 0);
    chk_stats0("mid_rst", 0, 0, 0, 0);
    @(negedge clk); rst = 1'b0;
    run(0, 0, cyc);
    chk("after_rst_lat", 32'(cyc), 17);
    chk_stats0("after_rst", 3, 20, 12, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
